// File: rtl/ssd_state_gen.sv
// Button-driven 2-bit state source for the seven-segment decoder: sync, debounce, edge detect, wrap-around stepping.
// Optional macro AUTO_ADVANCE_EN adds an idle timeout that steps the state forward on its own.
module ssd_state_gen #(
    parameter int DB_CYCLES      = 16,
    parameter int DB_W           = 20,
    parameter int TIMEOUT_CYCLES = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       enable,
    output logic [1:0] state,
    output logic       state_changed
);

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_t;

    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);

    // Reject parameter sets the debounce counter or idle timer cannot represent.
    if (DB_CYCLES < 1 || TIMEOUT_CYCLES < 2 || (64'd1 << DB_W) <= 64'(DB_CYCLES)) begin : g_param_check
        $error("ssd_state_gen: illegal DB_CYCLES/DB_W/TIMEOUT_CYCLES combination");
    end

    // Bit 1 carries btn_next, bit 0 carries btn_prev throughout.
    logic [1:0]            sync1_q;
    logic [1:0]            sync2_q;
    logic [1:0]            stable_q;
    logic [1:0]            stable_d;
    logic [1:0]            stable_dly_q;
    logic [1:0][DB_W-1:0]  cnt_q;
    logic [1:0][DB_W-1:0]  cnt_d;
    logic [1:0]            press_s;
    logic                  step_fwd_s;
    logic                  step_back_s;
    logic                  press_any_s;
    logic                  timeout_s;
    state_t                state_q;
    state_t                state_d;
    logic                  state_changed_q;
    logic                  state_changed_d;

    // Debounce: a synced level is accepted only after DB_CYCLES consecutive disagreeing samples.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = {DB_W{1'b0}};
            end else if (cnt_q[i] == DB_MAX) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = {DB_W{1'b0}};
            end else begin
                cnt_d[i] = cnt_q[i] + DB_W'(1);
            end
        end
    end

    assign press_s     = stable_q & ~stable_dly_q;
    assign step_fwd_s  = enable & press_s[1] & ~press_s[0];
    assign step_back_s = enable & press_s[0] & ~press_s[1];
    assign press_any_s = enable & (press_s[1] | press_s[0]);

`ifdef AUTO_ADVANCE_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [IDLE_W-1:0] idle_q;
    logic [IDLE_W-1:0] idle_d;

    // Idle timer: a press in the same cycle as expiry wins and restarts the count.
    always_comb begin
        idle_d    = idle_q;
        timeout_s = 1'b0;
        if (press_any_s) begin
            idle_d = {IDLE_W{1'b0}};
        end else if (!enable) begin
            idle_d = {IDLE_W{1'b0}};
        end else if (idle_q == IDLE_MAX) begin
            idle_d    = {IDLE_W{1'b0}};
            timeout_s = 1'b1;
        end else begin
            idle_d = idle_q + IDLE_W'(1);
        end
    end

    // Idle timer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= {IDLE_W{1'b0}};
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // State stepping; simultaneous presses cancel and produce no strobe.
    always_comb begin
        state_d = state_q;
        case ({step_fwd_s, step_back_s})
            2'b10:   state_d = state_t'(state_q + 2'd1);
            2'b01:   state_d = state_t'(state_q - 2'd1);
            2'b00: begin
                if (timeout_s && !press_any_s) begin
                    state_d = state_t'(state_q + 2'd1);
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = state_q;
        endcase
        state_changed_d = (state_d != state_q);
    end

    // All sequential state; async reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q         <= 2'b00;
            sync2_q         <= 2'b00;
            stable_q        <= 2'b00;
            stable_dly_q    <= 2'b00;
            cnt_q           <= '0;
            state_q         <= S0;
            state_changed_q <= 1'b0;
        end else begin
            sync1_q         <= {btn_next, btn_prev};
            sync2_q         <= sync1_q;
            stable_q        <= stable_d;
            stable_dly_q    <= stable_q;
            cnt_q           <= cnt_d;
            state_q         <= state_d;
            state_changed_q <= state_changed_d;
        end
    end

    assign state         = state_q;
    assign state_changed = state_changed_q;

endmodule

// File: tb/tb_ssd_state_gen.sv
// Randomized and directed bench for ssd_state_gen against a cycle-level behavioural model of the button pipeline.
module tb_ssd_state_gen;

    localparam int DB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_prev = 1'b0;
    logic       enable = 1'b1;
    logic [1:0] state;
    logic       state_changed;

    int checks = 0;
    int errors = 0;

    // Model: raw history (two-sample delay), accepted levels, run lengths, state.
    logic [1:0] h0, h1, m_stab, m_stab_dly, m_state;
    logic       m_chg;
    int         run_len [2];

    always #5 clk = ~clk;

    ssd_state_gen #(.DB_CYCLES(DB), .DB_W(20), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst_n(rst_n), .btn_next(btn_next), .btn_prev(btn_prev),
        .enable(enable), .state(state), .state_changed(state_changed)
    );

    task automatic model_reset();
        h0 = 2'b00; h1 = 2'b00; m_stab = 2'b00; m_stab_dly = 2'b00;
        m_state = 2'b00; m_chg = 1'b0; run_len[0] = 0; run_len[1] = 0;
    endtask

    // One clock edge: model advanced with the inputs present at the edge, bad set on any output disagreement.
    task automatic tick(output bit bad);
        logic [1:0] raw, rise, nxt, seen;
        logic       en;
        raw = {btn_next, btn_prev};
        en  = enable;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            rise = m_stab & ~m_stab_dly;
            nxt  = m_state;
            if (en && rise == 2'b10) nxt = m_state + 2'd1;
            else if (en && rise == 2'b01) nxt = m_state - 2'd1;
            m_chg = (nxt != m_state);
            m_state = nxt;
            m_stab_dly = m_stab;
            seen = h1;
            for (int i = 0; i < 2; i++) begin
                if (seen[i] != m_stab[i]) begin
                    run_len[i]++;
                    if (run_len[i] == DB) begin
                        m_stab[i] = seen[i];
                        run_len[i] = 0;
                    end
                end else begin
                    run_len[i] = 0;
                end
            end
            h1 = h0;
            h0 = raw;
        end
        #1;
        bad = (state !== m_state) || (state_changed !== m_chg);
    endtask

    task automatic run(input int n, output int bad_cnt);
        bit b;
        bad_cnt = 0;
        for (int k = 0; k < n; k++) begin
            tick(b);
            if (b) bad_cnt++;
        end
    endtask

    // Clean press of the selected buttons ({next,prev}) long enough to be accepted, then a clean release.
    task automatic press(input logic [1:0] which, output int bad_cnt);
        int b1, b2;
        btn_next = which[1];
        btn_prev = which[0];
        run(24, b1);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        run(24, b2);
        bad_cnt = b1 + b2;
    endtask

    task automatic test_reset();
        bit b;
        int strobes, bad;
        rst_n = 1'b0;
        bad = 0;
        strobes = 0;
        for (int k = 0; k < 5; k++) begin
            btn_next = 1'($urandom_range(0, 1));
            btn_prev = 1'($urandom_range(0, 1));
            tick(b);
            checks++;
            if (state !== 2'b00 || state_changed !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cycle=%0d got state=%b chg=%b exp state=00 chg=0", k, state, state_changed);
            end
        end
        btn_next = 1'b0;
        btn_prev = 1'b0;
        rst_n = 1'b1;
        run(30, bad);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_release got %0d bad cycles exp 0", bad);
        end
    endtask

    task automatic test_bounce();
        int bad, b, strobes;
        bit bb;
        bad = 0;
        strobes = 0;
        for (int r = 0; r < 5; r++) begin
            btn_next = 1'b1;
            for (int k = 0; k < 10; k++) begin tick(bb); bad += int'(bb); strobes += int'(state_changed); end
            btn_next = 1'b0;
            for (int k = 0; k < 3; k++) begin tick(bb); bad += int'(bb); strobes += int'(state_changed); end
        end
        run(40, b);
        bad += b;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL bounce_model got %0d bad cycles exp 0", bad); end
        checks++;
        if (strobes !== 0 || state !== 2'b00) begin
            errors++;
            $display("FAIL bounce_reject got state=%b strobes=%0d exp state=00 strobes=0", state, strobes);
        end
    endtask

    task automatic test_step();
        int lat, bad, strobes, b;
        bit bb;
        lat = 0;
        bad = 0;
        strobes = 0;
        btn_next = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            tick(bb);
            bad += int'(bb);
            strobes += int'(state_changed);
            if (state_changed === 1'b1 && lat == 0) lat = e;
        end
        checks++;
        if (lat !== 19) begin errors++; $display("FAIL step_latency got edge %0d exp edge 19", lat); end
        checks++;
        if (state !== 2'b01 || strobes !== 1) begin
            errors++;
            $display("FAIL step_value got state=%b strobes=%0d exp state=01 strobes=1", state, strobes);
        end
        strobes = 0;
        for (int k = 0; k < 200; k++) begin tick(bb); bad += int'(bb); strobes += int'(state_changed); end
        checks++;
        if (strobes !== 0 || state !== 2'b01) begin
            errors++;
            $display("FAIL step_hold got state=%b strobes=%0d exp state=01 strobes=0", state, strobes);
        end
        btn_next = 1'b0;
        run(30, b);
        bad += b;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL step_model got %0d bad cycles exp 0", bad); end
    endtask

    task automatic test_wrap();
        logic [1:0] exp_seq [5];
        logic [1:0] dirs [5];
        int b;
        bit bb;
        exp_seq = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b11};
        dirs    = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
        rst_n = 1'b0;
        tick(bb);
        rst_n = 1'b1;
        for (int p = 0; p < 5; p++) begin
            press(dirs[p], b);
            checks++;
            if (state !== exp_seq[p] || b !== 0) begin
                errors++;
                $display("FAIL wrap_%0d got state=%b bad=%0d exp state=%b bad=0", p, state, b, exp_seq[p]);
            end
        end
    endtask

    task automatic test_simul_enable();
        int b, strobes;
        bit bb;
        strobes = 0;
        btn_next = 1'b1;
        btn_prev = 1'b1;
        for (int k = 0; k < 30; k++) begin tick(bb); b += int'(bb); strobes += int'(state_changed); end
        btn_next = 1'b0;
        btn_prev = 1'b0;
        for (int k = 0; k < 30; k++) begin tick(bb); strobes += int'(state_changed); end
        checks++;
        if (state !== 2'b11 || strobes !== 0) begin
            errors++;
            $display("FAIL simultaneous got state=%b strobes=%0d exp state=11 strobes=0", state, strobes);
        end
        enable = 1'b0;
        btn_next = 1'b1;
        for (int k = 0; k < 24; k++) begin tick(bb); strobes += int'(state_changed); end
        btn_next = 1'b0;
        for (int k = 0; k < 24; k++) begin tick(bb); strobes += int'(state_changed); end
        enable = 1'b1;
        for (int k = 0; k < 40; k++) begin tick(bb); strobes += int'(state_changed); end
        checks++;
        if (state !== 2'b11 || strobes !== 0) begin
            errors++;
            $display("FAIL enable_drop got state=%b strobes=%0d exp state=11 strobes=0", state, strobes);
        end
    endtask

    task automatic test_reset_mid();
        int b, lat;
        bit bb;
        lat = 0;
        btn_next = 1'b1;
        run(10, b);
        rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 2'b00 || state_changed !== 1'b0) begin
            errors++;
            $display("FAIL reset_async got state=%b chg=%b exp state=00 chg=0", state, state_changed);
        end
        tick(bb);
        rst_n = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            tick(bb);
            if (state_changed === 1'b1 && lat == 0) lat = e;
        end
        checks++;
        if (lat !== 19 || state !== 2'b01) begin
            errors++;
            $display("FAIL reset_mid got edge=%0d state=%b exp edge=19 state=01", lat, state);
        end
        btn_next = 1'b0;
        run(30, b);
    endtask

    task automatic test_random();
        int b, len;
        for (int seg = 0; seg < 60; seg++) begin
            btn_next = 1'($urandom_range(0, 1));
            btn_prev = 1'($urandom_range(0, 1));
            enable   = ($urandom_range(0, 3) != 0);
            len = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 12)) : int'($urandom_range(18, 45));
            run(len, b);
            checks++;
            if (b !== 0) begin
                errors++;
                $display("FAIL random_seg%0d got %0d bad cycles exp 0 (state=%b model=%b)", seg, b, state, m_state);
            end
        end
        btn_next = 1'b0;
        btn_prev = 1'b0;
        enable = 1'b1;
        run(40, b);
        checks++;
        if (b !== 0) begin errors++; $display("FAIL random_drain got %0d bad cycles exp 0", b); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_bounce();
        test_step();
        test_wrap();
        test_simul_enable();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ssd_state_gen.md
Name: ssd_state_gen

Overview:
Producer side of the 2-bit `state` bus that the seven-segment display block decodes.
- Takes two raw, asynchronous push-buttons (next/prev).
- Synchronizes and debounces each one, then steps a 4-state wrap-around state register.
- Presents `state[1:0]` plus a one-cycle change strobe to the display logic.
- Sits between the board buttons and the SSD decoder.

Parameters:
DB_CYCLES, 16, consecutive cycles a synchronized level must hold before it is accepted (board build overrides to 1000000)
DB_W, 20, width of each debounce counter; must satisfy 2^DB_W > DB_CYCLES
TIMEOUT_CYCLES, 100, idle cycles before auto-advance (used only with AUTO_ADVANCE_EN)

Ports:
clk  input  1  system clock, all logic rising-edge
rst_n  input  1  asynchronous active-low reset
btn_next  input  1  raw button, active-high, asynchronous to clk
btn_prev  input  1  raw button, active-high, asynchronous to clk
enable  input  1  when low, accepted presses are discarded, not queued
state  output  2  current state, drives the SSD decoder `state` input
state_changed  output  1  one-cycle pulse, coincident with the first cycle `state` shows a new value

Behaviour:
Reset:
- One clock; reset is asynchronous and active-low (rst_n); the clock port is clk.
- Asserting rst_n=0, including mid-debounce or mid-count, immediately clears:
  - state=2'b00, state_changed=0
  - all synchronizer flops, debounced levels, delayed levels and counters.
- Deassertion takes effect on the next clk edge.

Synchronizer:
- 2-flop synchronizer per button, reset value 0.

Debounce (per button):
- stable level register and DB_W counter.
- Synced value == stable: counter cleared to 0.
- Otherwise counter increments. When the counter equals DB_CYCLES-1 and values still differ, the next edge loads stable from the synced value and clears the counter.
- Any glitch back to the stable value before that point clears the counter.
- Release is debounced with the same rule.

Press detect:
- press = stable & ~stable_d (combinational), where stable_d is the registered previous stable value.
- Exactly one press per debounced rising level. Holding a button never repeats.

State update:
- FSM states S0=00, S1=01, S2=10, S3=11.
- next-only press: state <= state+1 mod 4 (S3->S0).
- prev-only press: state <= state-1 mod 4 (S0->S3).
- Both presses in the same cycle: no change, no strobe.
- enable=0 in the press cycle: press dropped, no change.

state_changed:
- Registered. It is 1 in exactly the cycles where `state` differs from its value in the previous cycle, otherwise 0.

Latency:
- Count edge 1 as the first edge sampling btn_next=1, with the button held clean.
- New `state` and state_changed=1 are visible after edge DB_CYCLES+3, i.e. edge 19 with defaults.

Optional Feature:
Macro: AUTO_ADVANCE_EN

Defined:
- Adds an idle counter (width $clog2(TIMEOUT_CYCLES)+1).
- Counts every cycle with enable=1 and no state change.
- When it reaches TIMEOUT_CYCLES-1, the next edge applies state+1 mod 4, pulses state_changed and clears the counter.
- Any press-driven change clears the counter.
- enable=0 holds the counter at 0.
- If a press and the timeout land in the same cycle, the press wins and the timeout is discarded.

Undefined:
- No idle counter exists; state changes only on presses.
- TIMEOUT_CYCLES is unused.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles with buttons toggling -> state=00, state_changed=0 throughout.
- Debounced step: btn_next high and held -> state 00->01 after edge 19; state_changed high exactly 1 cycle; holding 200 more cycles gives no further change.
- Bounce rejection: btn_next pulses 10 cycles high, 3 low, repeated 5 times, then low -> state unchanged at 00, state_changed never 1.
- Wrap-around: 4 clean next presses from 00 -> 01,10,11,00. Then 1 clean prev press -> 11.
- Simultaneous and enable: both buttons pressed with identical timing -> no change. Single next press with enable=0 -> no change, and re-enabling does not replay it.
- Reset mid-operation: assert rst_n=0 at edge 10 of a debounce window, release, hold button -> full 19-edge latency restarts, state goes 00->01. With AUTO_ADVANCE_EN: idle from reset -> state=01 after edge 100, 10 after edge 200.
